// File: rtl/countdown_pkg.sv
// countdown_pkg: shared definitions for the mm:ss countdown timer.
//   state_e   - controller states (IDLE, RUN, PAUSE, ALARM)
//   SEC_MAX   - highest seconds value, wrap/borrow point
//   TIME_ZERO - the 00:00 value of a minute or second field
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_e;

    localparam int SEC_MAX   = 59;
    localparam int TIME_ZERO = 0;

endpackage

// File: rtl/mmss_down_counter.sv
// mmss_down_counter: loadable minutes:seconds pair with decrement enable.
//   clk, reset_n          - clock, async active-low reset
//   clr_i                 - force count to 00:00 (highest priority)
//   load_i, ld_min_i/_sec - load a new mm:ss value
//   dec_i                 - decrement by one second, borrowing into minutes
//   min_o, sec_o          - current count
//   nxt_min_o, nxt_sec_o  - value the count takes at the next edge
//   zero_o, nxt_zero_o    - current / next count equals 00:00
module mmss_down_counter
    import countdown_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] ld_min_i,
    input  logic [W-1:0] ld_sec_i,
    input  logic         dec_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] sec_o,
    output logic [W-1:0] nxt_min_o,
    output logic [W-1:0] nxt_sec_o,
    output logic         zero_o,
    output logic         nxt_zero_o
);

    logic [W-1:0] min_q, min_d;
    logic [W-1:0] sec_q, sec_d;

    assign zero_o = (min_q == W'(TIME_ZERO)) && (sec_q == W'(TIME_ZERO));

    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        if (clr_i) begin
            min_d = W'(TIME_ZERO);
            sec_d = W'(TIME_ZERO);
        end else if (load_i) begin
            min_d = ld_min_i;
            sec_d = ld_sec_i;
        end else if (dec_i && !zero_o) begin
            // Borrow a minute only once seconds are exhausted; the zero
            // guard keeps the count from wrapping below 00:00.
            if (sec_q != W'(TIME_ZERO)) begin
                sec_d = sec_q - W'(1);
            end else begin
                sec_d = W'(SEC_MAX);
                min_d = min_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '0;
            sec_q <= '0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign min_o      = min_q;
    assign sec_o      = sec_q;
    assign nxt_min_o  = min_d;
    assign nxt_sec_o  = sec_d;
    assign nxt_zero_o = (min_d == W'(TIME_ZERO)) && (sec_d == W'(TIME_ZERO));

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown with preset, pause and buzzer alarm.
//   clk, reset_n        - clock, async active-low reset
//   tick_1hz            - one-clk enable, once per second
//   start / stop        - one-clk control pulses (stop > start > tick)
//   set_min / set_sec   - one-clk preset increments, honoured in IDLE only
//   min_out / sec_out   - displayed time (preset in IDLE, count otherwise)
//   running             - high in RUN
//   done                - one-clk pulse on entry to ALARM
//   buzzer              - buzzer drive
// Optional: COUNTDOWN_TIMER_BLINK_EN makes the alarm beep intermittently
// (buzzer toggles per tick) and blanks the paused display on alternate ticks.
// All outputs are registered from next-state values, so every response is
// visible one clk after the input that caused it.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int MAX_MIN   = 59,
    parameter int RING_SECS = 10,
    parameter int W         = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick_1hz,
    input  logic         start,
    input  logic         stop,
    input  logic         set_min,
    input  logic         set_sec,
    output logic [W-1:0] min_out,
    output logic [W-1:0] sec_out,
    output logic         running,
    output logic         done,
    output logic         buzzer
);

    localparam int RW = $clog2(RING_SECS + 1);

    state_e       state_q, state_d;
    logic [W-1:0] pmin_q, pmin_d;
    logic [W-1:0] psec_q, psec_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [W-1:0] min_out_q, min_out_d;
    logic [W-1:0] sec_out_q, sec_out_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic         buzzer_q, buzzer_d;

    logic         cnt_clr, cnt_load, cnt_dec;
    logic [W-1:0] cnt_min, cnt_sec, cnt_nxt_min, cnt_nxt_sec;
    logic         cnt_zero, cnt_nxt_zero;
    logic         preset_zero;

`ifdef COUNTDOWN_TIMER_BLINK_EN
    logic         blank_q, blank_d;
`endif

    mmss_down_counter #(.W(W)) u_count (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .ld_min_i   (pmin_q),
        .ld_sec_i   (psec_q),
        .dec_i      (cnt_dec),
        .min_o      (cnt_min),
        .sec_o      (cnt_sec),
        .nxt_min_o  (cnt_nxt_min),
        .nxt_sec_o  (cnt_nxt_sec),
        .zero_o     (cnt_zero),
        .nxt_zero_o (cnt_nxt_zero)
    );

    assign preset_zero = (pmin_q == W'(TIME_ZERO)) && (psec_q == W'(TIME_ZERO));

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pmin_d   = pmin_q;
        psec_d   = psec_q;
        ring_d   = ring_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_min) pmin_d = (pmin_q == W'(MAX_MIN)) ? W'(TIME_ZERO) : pmin_q + W'(1);
                if (set_sec) psec_d = (psec_q == W'(SEC_MAX)) ? W'(TIME_ZERO) : psec_q + W'(1);
                if (!stop && start && !preset_zero) begin
                    cnt_load = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (!start && tick_1hz) begin
                    cnt_dec = 1'b1;
                    if (cnt_nxt_zero) begin
                        state_d = ALARM;
                        done_d  = 1'b1;
                        ring_d  = '0;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (stop || start) begin
                    state_d = IDLE;
                end else if (tick_1hz) begin
                    ring_d = ring_q + RW'(1);
                    if (ring_d == RW'(RING_SECS)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic, evaluated on next state so outputs register cleanly
    always_comb begin
        running_d = (state_d == RUN);
        min_out_d = cnt_nxt_min;
        sec_out_d = cnt_nxt_sec;
        buzzer_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_BLINK_EN
        blank_d   = 1'b0;
        if (state_q == PAUSE && state_d == PAUSE) begin
            blank_d = tick_1hz ? ~blank_q : blank_q;
        end
`endif
        unique case (state_d)
            IDLE: begin
                min_out_d = pmin_d;
                sec_out_d = psec_d;
            end
            ALARM: begin
                min_out_d = W'(TIME_ZERO);
                sec_out_d = W'(TIME_ZERO);
`ifdef COUNTDOWN_TIMER_BLINK_EN
                // Start high on entry, then flip on each tick while ringing.
                if (state_q != ALARM)  buzzer_d = 1'b1;
                else if (tick_1hz)     buzzer_d = ~buzzer_q;
                else                   buzzer_d = buzzer_q;
`else
                buzzer_d  = 1'b1;
`endif
            end
`ifdef COUNTDOWN_TIMER_BLINK_EN
            PAUSE: begin
                if (blank_d) begin
                    min_out_d = W'(TIME_ZERO);
                    sec_out_d = W'(TIME_ZERO);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pmin_q    <= '0;
            psec_q    <= '0;
            ring_q    <= '0;
            min_out_q <= '0;
            sec_out_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            buzzer_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pmin_q    <= pmin_d;
            psec_q    <= psec_d;
            ring_q    <= ring_d;
            min_out_q <= min_out_d;
            sec_out_q <= sec_out_d;
            running_q <= running_d;
            done_q    <= done_d;
            buzzer_q  <= buzzer_d;
        end
    end

`ifdef COUNTDOWN_TIMER_BLINK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) blank_q <= 1'b0;
        else          blank_q <= blank_d;
    end
`endif

    assign min_out = min_out_q;
    assign sec_out = sec_out_q;
    assign running = running_q;
    assign done    = done_q;
    assign buzzer  = buzzer_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tick_1hz = 1'b0, start = 1'b0, stop = 1'b0;
    logic         set_min = 1'b0, set_sec = 1'b0;
    logic [W-1:0] min_out, sec_out;
    logic         running, done, buzzer;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.MAX_MIN(59), .RING_SECS(10), .W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick_1hz (tick_1hz),
        .start    (start),
        .stop     (stop),
        .set_min  (set_min),
        .set_sec  (set_sec),
        .min_out  (min_out),
        .sec_out  (sec_out),
        .running  (running),
        .done     (done),
        .buzzer   (buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; outputs are sampled 1 time
    // unit after the edge by the caller.
    task automatic cyc(input logic st, input logic sp, input logic tk,
                       input logic sm, input logic ss);
        start = st; stop = sp; tick_1hz = tk; set_min = sm; set_sec = ss;
        @(posedge clk); #1;
        start = 0; stop = 0; tick_1hz = 0; set_min = 0; set_sec = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, 0);
    endtask

    task automatic mins(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        chk({tag, ".min"}, int'(min_out), m);
        chk({tag, ".sec"}, int'(sec_out), s);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_time("rst", 0, 0);
        chk("rst.running", int'(running), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.buzzer", int'(buzzer), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1. Preset wrap
        mins(59);
        chk("wrap.min59", int'(min_out), 59);
        mins(1);
        chk("wrap.min0", int'(min_out), 0);
        secs(61);
        chk_time("wrap.sec", 0, 1);
        cyc(0, 0, 0, 1, 1);                 // both increments together
        chk_time("both", 1, 2);
        secs(58);                            // 2 + 58 = 60 -> 0
        chk_time("preset0100", 1, 0);

        // 2. Borrow and countdown to zero
        cyc(1, 0, 0, 0, 0);
        chk("run.running", int'(running), 1);
        chk_time("run.start", 1, 0);
        ticks(1);
        chk_time("borrow", 0, 59);
        ticks(58);
        chk_time("run.0001", 0, 1);
        ticks(1);
        chk_time("alarm", 0, 0);
        chk("alarm.done", int'(done), 1);
        chk("alarm.buzzer", int'(buzzer), 1);
        chk("alarm.running", int'(running), 0);
        cyc(0, 0, 0, 0, 0);
        chk("alarm.done_pulse", int'(done), 0);
        chk("alarm.buzz_hold", int'(buzzer), 1);

        // 3. Ring timeout
        ticks(9);
        chk("ring9.buzzer", int'(buzzer), 1);
        ticks(1);
        chk("ring10.buzzer", int'(buzzer), 0);
        chk_time("ring.idle", 1, 0);
        chk("ring.running", int'(running), 0);

        // 4. Pause / resume with preset 00:05
        mins(59);                            // 1 -> 0 after 59 steps
        secs(5);
        chk_time("preset0005", 0, 5);
        cyc(1, 0, 0, 0, 0);
        ticks(2);
        chk_time("p.0003", 0, 3);
        cyc(0, 1, 1, 0, 0);                  // stop wins over tick
        chk_time("p.stop_tick", 0, 3);
        chk("p.running", int'(running), 0);
        ticks(3);
        chk_time("p.held", 0, 3);
        cyc(1, 0, 0, 0, 0);
        chk("p.resume", int'(running), 1);
        ticks(1);
        chk_time("p.0002", 0, 2);
        cyc(0, 1, 0, 0, 0);
        chk_time("p.pause2", 0, 2);
        cyc(0, 1, 0, 0, 0);
        chk_time("p.idle", 0, 5);

        // 5. Edge guards
        cyc(1, 1, 0, 0, 0);                  // start+stop acts as stop
        chk("g.startstop", int'(running), 0);
        secs(55);                            // 5 + 55 = 60 -> 0
        chk_time("g.preset0", 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("g.start_zero", int'(running), 0);
        secs(5);
        cyc(1, 0, 0, 0, 0);
        chk("g.run", int'(running), 1);
        secs(3);                             // ignored in RUN
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk_time("g.preset_kept", 0, 5);

        // 6. Async reset during ALARM
        cyc(1, 0, 0, 0, 0);
        ticks(5);
        chk("r.buzzer", int'(buzzer), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r.async_buzzer", int'(buzzer), 0);
        chk_time("r.async", 0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0);                  // preset cleared -> start ignored
        chk("r.idle_running", int'(running), 0);
        chk_time("r.preset", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
